// File: rtl/synthesis_combiner_pkg.sv
// Shared constants, types and helpers for the synthesis combiner.
// Sample formats: subband input sfix37_En32, gains sfix16_En14,
// accumulator sfix57_En46, reconstructed output sfix15_En14.
package synth_pkg;

    localparam int NUM_CHAN    = 16;
    localparam int CNT_W       = $clog2(NUM_CHAN);
    localparam int IN_W        = 37;
    localparam int GAIN_W      = 16;
    localparam int PROD_W      = IN_W + GAIN_W;
    localparam int ACC_W       = 57;
    localparam int OUT_W       = 15;
    localparam int ROUND_SHIFT = 32;
    localparam int RND_W       = ACC_W + 1 - ROUND_SHIFT;

    localparam logic [CNT_W-1:0] LAST_CHAN = CNT_W'(NUM_CHAN - 1);

    // Per-channel synthesis gains, sfix16_En14; 16384 is unity.
    localparam logic signed [GAIN_W-1:0] CHAN_GAIN [NUM_CHAN] = '{NUM_CHAN{16'sd16384}};

    typedef enum logic {
        ACCUM = 1'b0,
        ROUND = 1'b1
    } state_e;

    // Sign-extend a full-precision product onto the accumulator width.
    function automatic logic signed [ACC_W-1:0] widenProduct(input logic signed [PROD_W-1:0] prod);
        return {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
    endfunction

endpackage

// File: rtl/synthesis_combiner_round_sat.sv
// Purely combinational round-half-up and saturate from the En46
// accumulator down to the sfix15_En14 output format.
module synth_round_sat
    import synth_pkg::*;
(
    input  logic signed [ACC_W-1:0] acc_i,
    output logic signed [OUT_W-1:0] data_o
);

    // 2^(ROUND_SHIFT-1): half an output LSB expressed in accumulator units.
    localparam logic [ACC_W:0] ROUND_BIAS =
        {{(ACC_W - ROUND_SHIFT + 1){1'b0}}, 1'b1, {(ROUND_SHIFT - 1){1'b0}}};

    logic signed [ACC_W:0]   biased;
    logic signed [RND_W-1:0] rnd;
    logic                    posOverflow;
    logic                    negOverflow;
    logic                    unusedLowBits;

    // Add half an LSB one bit wider than the accumulator, then keep the integer part.
    always_comb begin
        biased = {acc_i[ACC_W-1], acc_i} + ROUND_BIAS;
        rnd    = biased[ACC_W:ROUND_SHIFT];
    end

    // The rounded value fits the output only if every bit above the output sign matches it.
    always_comb begin
        posOverflow = ~rnd[RND_W-1] & (|rnd[RND_W-2:OUT_W-1]);
        negOverflow = rnd[RND_W-1] & ~(&rnd[RND_W-2:OUT_W-1]);
        data_o      = rnd[OUT_W-1:0];
        if (posOverflow) begin
            data_o = {1'b0, {(OUT_W - 1){1'b1}}};
        end else if (negOverflow) begin
            data_o = {1'b1, {(OUT_W - 1){1'b0}}};
        end
    end

    assign unusedLowBits = ^biased[ROUND_SHIFT-1:0];

endmodule

// File: rtl/synthesis_combiner.sv
// Synthesis combiner: weights 16 serial subband samples by per-channel
// gains, accumulates one frame, then rounds and saturates the sum into one
// reconstructed sample. Optional channel-order checking and the sticky err
// port are enabled by defining SYNTH_CHAN_CHECK_EN.
module synthesis_combiner
    import synth_pkg::*;
(
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    clk_enable,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [IN_W-1:0]  in_data,
    input  logic [CNT_W-1:0]        in_chan,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_data
`ifdef SYNTH_CHAN_CHECK_EN
    ,
    output logic                    err
`endif
);

    state_e                   state_q;
    logic signed [ACC_W-1:0]  accSum_q;
    logic signed [ACC_W-1:0]  accSum_d;
    logic [CNT_W-1:0]         chanCnt_q;
    logic                     outValid_q;
    logic signed [OUT_W-1:0]  outData_q;

    logic                     accept;
    logic                     outFree;
    logic                     chanMismatch;
    logic                     chanRestart;
    logic [CNT_W-1:0]         gainIdx;
    logic signed [GAIN_W-1:0] gain;
    logic signed [PROD_W-1:0] dataExt;
    logic signed [PROD_W-1:0] gainExt;
    logic signed [PROD_W-1:0] product;
    logic signed [ACC_W-1:0]  prodWide;
    logic signed [OUT_W-1:0]  roundedData;

`ifdef SYNTH_CHAN_CHECK_EN
    logic                     err_q;
`else
    logic                     unusedChan;
`endif

    // Input is only taken while accumulating; reset and a low enable both block it.
    assign in_ready = clk_enable & ~reset & (state_q == ACCUM);
    assign accept   = in_valid & in_ready;
    assign outFree  = ~outValid_q | out_ready;

    // Channel-order check: a wrong index aborts the frame, and index 0 restarts it.
    always_comb begin
        chanMismatch = 1'b0;
        chanRestart  = 1'b0;
        gainIdx      = chanCnt_q;
`ifdef SYNTH_CHAN_CHECK_EN
        chanMismatch = (in_chan != chanCnt_q);
        chanRestart  = chanMismatch & (in_chan == '0);
        if (chanRestart) begin
            gainIdx = '0;
        end
`endif
    end

`ifndef SYNTH_CHAN_CHECK_EN
    assign unusedChan = ^in_chan;
`endif

    // Single-cycle multiply of the sample by its channel gain, widened for the accumulator.
    always_comb begin
        gain     = CHAN_GAIN[gainIdx];
        dataExt  = {{GAIN_W{in_data[IN_W-1]}}, in_data};
        gainExt  = {{IN_W{gain[GAIN_W-1]}}, gain};
        product  = dataExt * gainExt;
        prodWide = widenProduct(product);
        accSum_d = accSum_q + prodWide;
    end

    synth_round_sat u_roundSat (
        .acc_i  (accSum_q),
        .data_o (roundedData)
    );

    // Frame FSM plus output register: accumulate 16 beats, then hand the rounded sum off.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ACCUM;
            accSum_q   <= '0;
            chanCnt_q  <= '0;
            outValid_q <= 1'b0;
            outData_q  <= '0;
`ifdef SYNTH_CHAN_CHECK_EN
            err_q      <= 1'b0;
`endif
        end else if (clk_enable) begin
            case (state_q)
                ACCUM: begin
                    if (accept) begin
                        if (chanMismatch) begin
`ifdef SYNTH_CHAN_CHECK_EN
                            err_q <= 1'b1;
`endif
                            if (chanRestart) begin
                                accSum_q  <= prodWide;
                                chanCnt_q <= CNT_W'(1);
                            end else begin
                                accSum_q  <= '0;
                                chanCnt_q <= '0;
                            end
                        end else begin
                            accSum_q <= accSum_d;
                            if (chanCnt_q == LAST_CHAN) begin
                                state_q <= ROUND;
                            end else begin
                                chanCnt_q <= chanCnt_q + CNT_W'(1);
                            end
                        end
                    end
                end
                ROUND: begin
                    if (outFree) begin
                        accSum_q  <= '0;
                        chanCnt_q <= '0;
                        state_q   <= ACCUM;
                    end
                end
                default: begin
                    state_q <= ACCUM;
                end
            endcase

            if ((state_q == ROUND) && outFree) begin
                outValid_q <= 1'b1;
                outData_q  <= roundedData;
            end else if (outValid_q && out_ready) begin
                outValid_q <= 1'b0;
            end
        end
    end

    assign out_valid = outValid_q;
    assign out_data  = outData_q;
`ifdef SYNTH_CHAN_CHECK_EN
    assign err       = err_q;
`endif

endmodule

// File: tb/tb_synthesis_combiner.sv
// Directed testbench for synthesis_combiner with hand-computed results.
// Channel-order checks are compiled in when SYNTH_CHAN_CHECK_EN is defined.
module tb_synthesis_combiner;
    import synth_pkg::*;

    localparam logic signed [IN_W-1:0] P26  = 37'sd67108864;
    localparam logic signed [IN_W-1:0] P25  = 37'sd33554432;
    localparam logic signed [IN_W-1:0] P30  = 37'sd1073741824;
    localparam logic signed [IN_W-1:0] N30  = -37'sd1073741824;
    localparam logic signed [IN_W-1:0] P17  = 37'sd131072;
    localparam logic signed [IN_W-1:0] N17  = -37'sd131072;
    localparam logic signed [IN_W-1:0] ZERO = 37'sd0;

    logic                    clock = 1'b0;
    logic                    reset;
    logic                    clk_enable;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [IN_W-1:0]  in_data;
    logic [CNT_W-1:0]        in_chan;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] out_data;
`ifdef SYNTH_CHAN_CHECK_EN
    logic                    err;
`endif

    int compared   = 0;
    int mismatched = 0;

    always #5 clock = ~clock;

    synthesis_combiner dut (
        .clock      (clock),
        .reset      (reset),
        .clk_enable (clk_enable),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_chan    (in_chan),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data)
`ifdef SYNTH_CHAN_CHECK_EN
        ,
        .err        (err)
`endif
    );

    task automatic checkBit(input string tag, input logic observed, input logic expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(input string tag, input int expectedInt);
        logic signed [OUT_W-1:0] expected;
        expected = expectedInt[OUT_W-1:0];
        compared++;
        assert (out_data === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, out_data, expected);
        end
    endtask

    // Called at a negedge; returns at the negedge after the beat was accepted.
    task automatic applyStimulus(input logic signed [IN_W-1:0] data, input int chan);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_data  = data;
        in_chan  = CNT_W'(chan);
        while (!in_ready && guard < 100) begin
            @(negedge clock);
            guard++;
        end
        if (guard >= 100) begin
            compared++;
            mismatched++;
            $error("[TB] FAIL accept_timeout: observed in_ready=0 for 100 cycles expected 1");
        end else begin
            @(negedge clock);
        end
        in_valid = 1'b0;
    endtask

    task automatic sendFrame(input logic signed [IN_W-1:0] ch0Val, input logic signed [IN_W-1:0] restVal);
        for (int i = 0; i < NUM_CHAN; i++) begin
            applyStimulus((i == 0) ? ch0Val : restVal, i);
        end
    endtask

    // Output must appear exactly two edges after the last accept.
    task automatic expectOutput(input string tag, input int expectedInt);
        @(negedge clock);
        checkBit({tag, "_valid"}, out_valid, 1'b1);
        checkOutput(tag, expectedInt);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        clk_enable = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        in_chan    = '0;
        out_ready  = 1'b0;
        repeat (3) @(negedge clock);

        checkBit("reset_in_ready", in_ready, 1'b0);
        checkBit("reset_out_valid", out_valid, 1'b0);
        checkOutput("reset_out_data", 0);
`ifdef SYNTH_CHAN_CHECK_EN
        checkBit("reset_err", err, 1'b0);
`endif
        reset = 1'b0;
        @(negedge clock);
        checkBit("idle_in_ready", in_ready, 1'b1);

        $display("[TB] unity frame, 2^26 on every channel");
        sendFrame(P26, P26);
        checkBit("round_out_valid_low", out_valid, 1'b0);
        checkBit("round_in_ready_low", in_ready, 1'b0);
        expectOutput("unity_frame", 4096);
        checkBit("post_round_in_ready", in_ready, 1'b1);
        out_ready = 1'b1;
        @(negedge clock);
        checkBit("drain_out_valid", out_valid, 1'b0);

        $display("[TB] saturation frames");
        sendFrame(P30, P30);
        expectOutput("sat_pos", 16383);
        sendFrame(N30, N30);
        expectOutput("sat_neg", -16384);

        $display("[TB] rounding frames");
        sendFrame(P17, ZERO);
        expectOutput("round_half_pos", 1);
        sendFrame(N17, ZERO);
        expectOutput("round_half_neg", 0);
        @(negedge clock);
        checkBit("rounding_drained", out_valid, 1'b0);

        $display("[TB] backpressure across two frames");
        out_ready = 1'b0;
        sendFrame(P26, P26);
        expectOutput("bp_first", 4096);
        sendFrame(P25, P25);
        checkBit("bp_held_valid", out_valid, 1'b1);
        checkOutput("bp_held_data", 4096);
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            checkBit("bp_stall_in_ready", in_ready, 1'b0);
            checkOutput("bp_stall_data", 4096);
        end
        out_ready = 1'b1;
        @(negedge clock);
        checkBit("bp_second_valid", out_valid, 1'b1);
        checkOutput("bp_second_data", 2048);
        checkBit("bp_resume_in_ready", in_ready, 1'b1);
        @(negedge clock);
        checkBit("bp_drained", out_valid, 1'b0);

        $display("[TB] clock enable pause mid-frame");
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(P26, i);
        end
        clk_enable = 1'b0;
        in_valid   = 1'b1;
        in_data    = P30;
        in_chan    = CNT_W'(8);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            checkBit("pause_in_ready", in_ready, 1'b0);
        end
        in_valid   = 1'b0;
        clk_enable = 1'b1;
        for (int i = 8; i < NUM_CHAN; i++) begin
            applyStimulus(P26, i);
        end
        expectOutput("pause_frame", 4096);

        $display("[TB] reset at channel 7 with an output pending");
        for (int i = 0; i < 7; i++) begin
            applyStimulus(P30, i);
        end
        reset = 1'b1;
        #1;
        checkBit("midreset_out_valid", out_valid, 1'b0);
        checkOutput("midreset_out_data", 0);
        checkBit("midreset_in_ready", in_ready, 1'b0);
`ifdef SYNTH_CHAN_CHECK_EN
        checkBit("midreset_err", err, 1'b0);
`endif
        repeat (2) @(negedge clock);
        reset     = 1'b0;
        out_ready = 1'b1;
        @(negedge clock);
        sendFrame(P26, P26);
        expectOutput("after_reset_frame", 4096);

`ifdef SYNTH_CHAN_CHECK_EN
        $display("[TB] channel order checking");
        applyStimulus(P26, 0);
        applyStimulus(P26, 1);
        applyStimulus(P26, 2);
        applyStimulus(P30, 5);
        checkBit("order_err_set", err, 1'b1);
        checkBit("order_no_output", out_valid, 1'b0);
        checkBit("order_in_ready", in_ready, 1'b1);
        sendFrame(P26, P26);
        expectOutput("order_clean_frame", 4096);
        checkBit("order_err_sticky", err, 1'b1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(P30, i);
        end
        sendFrame(P26, P26);
        expectOutput("order_restart_frame", 4096);
        checkBit("order_err_still", err, 1'b1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/synthesis_combiner.md
# synthesis_combiner

Synthesis-side counterpart of the 16-channel nonuniform analysis filter bank. It accepts one frame of 16 subband samples (sfix37_En32), serially in channel order. Each sample is weighted by a per-channel synthesis gain and accumulated; the frame sum is rounded and saturated back to the front-end sample format (sfix15_En14). The block sits downstream of the per-channel subband processing and produces one reconstructed sample per frame.

## Interface
- NUM_CHAN, 16, channels per frame; fixed by the package, not overridable.
- clock  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- clk_enable  in  1  global enable. When low, all state freezes, in_ready is forced 0 and out_ready is ignored.
- in_valid  in  1  subband sample valid
- in_ready  out  1  block can accept a subband sample
- in_data  in  37  subband sample, sfix37_En32
- in_chan  in  4  channel index of in_data (0..15)
- out_valid  out  1  reconstructed sample valid
- out_ready  in  1  downstream accepts the sample
- out_data  out  15  reconstructed sample, sfix15_En14
- err  out  1  sticky channel-order error; only present with SYNTH_CHAN_CHECK_EN

## Operation
- Reset values: in_ready=0, out_valid=0, out_data=0, err=0, accumulator=0, channel counter=0, state=ACCUM.
- States:
  - ACCUM: in_ready = clk_enable.
  - ROUND: in_ready = 0.
- Accept: in_valid & in_ready on a rising edge.
- On each accept:
  - product = in_data × CHAN_GAIN[cnt], where CHAN_GAIN is sfix16_En14. The product is 53 bits, En46.
  - The product is sign-extended and added to a 57-bit En46 accumulator; 4 guard bits mean no overflow is possible.
  - cnt increments.
- ACCUM→ROUND on accept with cnt==15.
- ROUND computes rnd = (acc + 2^31) >>> 32, i.e. round half toward +inf. It then saturates rnd to [-16384, 16383].
- ROUND→ACCUM when the output register is free (out_valid==0, or out_ready==1 in the same cycle). On that edge:
  - out_data is loaded and out_valid is set.
  - acc and cnt are cleared.
- If the output register is not free, the block stays in ROUND with acc held.
- Output handshake: out_valid is held with out_data stable until out_ready. Completing a handshake without a new load clears out_valid.
- Simultaneous drain and load: new data is loaded and out_valid stays 1.
- Reset mid-frame: the partial frame is lost and all values return to their reset values.
- cnt wraps 15→0 only through ROUND, never in ACCUM.

## Timing
- Last channel accepted at edge T: state is ROUND during cycle T+1.
- If the output register is free, out_valid=1 from edge T+2; minimum frame-to-output latency is 2 cycles.
- Maximum throughput: 16 input beats plus 1 ROUND cycle, i.e. one output per 17 cycles.
- The input stalls only in ROUND. Each ROUND cycle spent waiting on out_ready adds one cycle.
- The multiply-accumulate is single-cycle. The product register is optional but must not change the latency above.

## Configuration
- SYNTH_CHAN_CHECK_EN defined:
  - Each accepted in_chan is compared to cnt.
  - On mismatch, err is set (sticky until reset) and acc and cnt are cleared.
  - The mismatching beat is discarded unless in_chan==0. In that case it is accumulated as channel 0 of a new frame and cnt becomes 1.
- SYNTH_CHAN_CHECK_EN undefined: in_chan is ignored, the err port is absent, and ordering is implied by cnt alone.

## Structure
- Package synth_pkg contains:
  - NUM_CHAN
  - widths: IN_W=37, GAIN_W=16, ACC_W=57, OUT_W=15
  - ROUND_SHIFT=32
  - CHAN_GAIN[0:15], default all 16384 (1.0)
  - state enum {ACCUM, ROUND}
- One sub-module, synth_round_sat: purely combinational round plus saturate from ACC_W to OUT_W. It is instantiated once and unit-testable on its own.

## Test plan
- Frame with in_data=2^26 on all 16 channels, unity gains → out_data=4096 (0.25). out_valid rises 2 cycles after the channel-15 accept.
- Frame with in_data=2^30 on all channels → sum is 4.0 → out_data=16383 (positive saturation). A frame with -2^30 on all channels → out_data=-16384.
- Rounding: channel 0 = 2^17, all others 0 → out_data=1. Channel 0 = -2^17 → out_data=0.
- Backpressure: out_ready=0 for 40 cycles across two frames. The first output is held stable, in_ready=0 throughout ROUND of the second frame, and both samples are delivered in order with no loss.
- clk_enable toggled low for 5 cycles mid-frame, and reset asserted mid-frame at channel 7. The first frame result is unchanged; after reset all outputs are 0 and the next full frame of 2^26 yields 4096.
- With SYNTH_CHAN_CHECK_EN, send in_chan order 0,1,2,5:
  - err=1 and the partial frame is dropped.
  - Then channels 0..15 at 2^26 → out_data=4096 with err still 1.
  - A second stream of channels 0..4 followed by a restart at 0 and a full frame → 4096.
